// File: rtl/ssg_tone_bank_if.sv
// ssg_tone_bank_if: register-write and tone-output bundle for ssg_tone_bank.
//
// Write port: WR_EN is a single-cycle strobe with no ready/back-pressure.
// The bank accepts a write on every PHI_S rising edge where WR_EN=1.
// WR_ADDR/WR_DATA only need to be valid on those edges. Only one write can
// happen per cycle.
//
// Signals:
//   WR_EN      write strobe                    (master -> slave)
//   WR_ADDR    channel index / noise address   (master -> slave)
//   WR_DATA    period value                    (master -> slave)
//   PHASE_RST  per-channel phase reset         (master -> slave)
//   TICK       prescaler wrap pulse            (slave -> master)
//   OSC_OUT    square wave per channel         (slave -> master)
//   NOISE_OUT  noise output                    (slave -> master)
interface ssg_tone_bank_if #(
  parameter int CH_COUNT = 3,
  parameter int PERIOD_W = 12,
  parameter int ADDR_W   = 2
);
  logic                WR_EN;
  logic [ADDR_W-1:0]   WR_ADDR;
  logic [PERIOD_W-1:0] WR_DATA;
  logic [CH_COUNT-1:0] PHASE_RST;
  logic                TICK;
  logic [CH_COUNT-1:0] OSC_OUT;
  logic                NOISE_OUT;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, PHASE_RST,
    input  TICK, OSC_OUT, NOISE_OUT
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, PHASE_RST,
    output TICK, OSC_OUT, NOISE_OUT
  );
endinterface

// File: rtl/ssg_tone_bank.sv
// ssg_tone_bank: multi-channel SSG square-wave tone generator.
//
// A shared prescaler produces a registered TICK every PRESCALE cycles of
// PHI_S. On each tick, every channel's counter advances toward its effective
// period. A period of 0 is treated as 1. When the counter expires, the counter
// clears and the channel output toggles.
//
// Optional noise generator: define SSG_NOISE_EN to build it. With the macro
// defined, address CH_COUNT writes a 5-bit noise period. The noise counter
// clocks a 17-bit LFSR, and NOISE_OUT is lfsr[0]. Without the macro,
// NOISE_OUT is 0 and no noise logic exists.
//
// Ports:
//   PHI_S   clock, rising edge
//   nRESET  asynchronous active-low reset
//   bus     ssg_tone_bank_if slave modport (write port, phase resets, outputs)
module ssg_tone_bank #(
  parameter int CH_COUNT = 3,
  parameter int PERIOD_W = 12,
  parameter int PRESCALE = 8,
  parameter int ADDR_W   = 2
) (
  input logic             PHI_S,
  input logic             nRESET,
  ssg_tone_bank_if.slave  bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // Prescaler. The next count is examined so that TICK is high during the
  // cycle in which the count equals PRESCALE-1. With PRESCALE=1, TICK stays
  // high after the first edge.
  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_nxt;
  logic             tick_q;

  always_comb begin
    pre_nxt = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
  end

  always_ff @(posedge PHI_S or negedge nRESET) begin
    if (!nRESET) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      tick_q  <= (pre_nxt == PRE_LAST);
    end
  end

  // Tone channels.
  logic [PERIOD_W-1:0] period [CH_COUNT];
  logic [PERIOD_W-1:0] cnt    [CH_COUNT];
  logic [PERIOD_W-1:0] eff    [CH_COUNT];
  logic [CH_COUNT-1:0] expire;
  logic [CH_COUNT-1:0] osc;

  // The compare uses one extra bit so that cnt+1 cannot wrap. When a period
  // is lowered below the running count, the channel therefore expires on the
  // next tick instead of running through 2^PERIOD_W.
  always_comb begin
    for (int i = 0; i < CH_COUNT; i++) begin
      eff[i]    = (period[i] == '0) ? PERIOD_W'(1) : period[i];
      expire[i] = (({1'b0, cnt[i]} + (PERIOD_W+1)'(1)) >= {1'b0, eff[i]});
    end
  end

  // A write landing on a tick edge is non-blocking, so the old period decides
  // this expiry. PHASE_RST has priority over a tick on the same edge.
  always_ff @(posedge PHI_S or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < CH_COUNT; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      osc <= '0;
    end else begin
      for (int i = 0; i < CH_COUNT; i++) begin
        if (bus.WR_EN && (bus.WR_ADDR == ADDR_W'(i))) begin
          period[i] <= bus.WR_DATA;
        end
        if (bus.PHASE_RST[i]) begin
          cnt[i] <= '0;
          osc[i] <= 1'b0;
        end else if (tick_q) begin
          if (expire[i]) begin
            cnt[i] <= '0;
            osc[i] <= ~osc[i];
          end else begin
            cnt[i] <= cnt[i] + PERIOD_W'(1);
          end
        end
      end
    end
  end

  assign bus.TICK    = tick_q;
  assign bus.OSC_OUT = osc;

`ifdef SSG_NOISE_EN
  localparam logic [ADDR_W-1:0] NOISE_ADDR = ADDR_W'(CH_COUNT);

  logic [4:0]  nper;
  logic [4:0]  ncnt;
  logic [4:0]  neff;
  logic        n_expire;
  logic [16:0] lfsr;

  always_comb begin
    neff     = (nper == 5'd0) ? 5'd1 : nper;
    n_expire = (({1'b0, ncnt} + 6'd1) >= {1'b0, neff});
  end

  // The noise counter follows the same rules as a tone channel. Each expiry
  // advances the LFSR by one step. PHASE_RST does not reach this logic.
  always_ff @(posedge PHI_S or negedge nRESET) begin
    if (!nRESET) begin
      nper <= 5'd0;
      ncnt <= 5'd0;
      lfsr <= 17'h00001;
    end else begin
      if (bus.WR_EN && (bus.WR_ADDR == NOISE_ADDR)) begin
        nper <= bus.WR_DATA[4:0];
      end
      if (tick_q) begin
        if (n_expire) begin
          ncnt <= 5'd0;
          lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ncnt <= ncnt + 5'd1;
        end
      end
    end
  end

  assign bus.NOISE_OUT = lfsr[0];
`else
  assign bus.NOISE_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_ssg_tone_bank.sv
// tb_ssg_tone_bank: randomized bench for ssg_tone_bank.
//
// Each driven cycle updates a behavioural model and pushes the outputs
// expected after the next PHI_S edge into exp_q. A separate monitor samples
// 1 ns after each rising edge, pops one entry, and compares it.
module tb_ssg_tone_bank;
  localparam int CH = 3;
  localparam int PW = 12;
  localparam int PS = 8;
  localparam int AW = 2;
  localparam int W  = CH + 2;   // {noise, osc[CH-1:0], tick}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ssg_tone_bank_if #(.CH_COUNT(CH), .PERIOD_W(PW), .ADDR_W(AW)) bus ();

  ssg_tone_bank #(.CH_COUNT(CH), .PERIOD_W(PW), .PRESCALE(PS), .ADDR_W(AW)) dut (
    .PHI_S  (clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model.
  int m_pre;
  int m_tick;
  int m_period[CH];
  int m_cnt[CH];
  int m_osc[CH];
  int m_nper;
  int m_ncnt;
  int m_lfsr;

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v;
    v = '0;
    v[0] = (m_tick != 0);
    for (int c = 0; c < CH; c++) v[c+1] = (m_osc[c] != 0);
`ifdef SSG_NOISE_EN
    v[CH+1] = m_lfsr[0];
`else
    v[CH+1] = 1'b0;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_pre  = 0;
    m_tick = 0;
    for (int c = 0; c < CH; c++) begin
      m_period[c] = 0;
      m_cnt[c]    = 0;
      m_osc[c]    = 0;
    end
    m_nper = 0;
    m_ncnt = 0;
    m_lfsr = 1;
  endtask

  // One rising edge with nRESET high. The TICK that is currently visible
  // decides whether the channels advance. Writes take effect after the
  // edge's compare.
  task automatic model_edge(input int we, input int addr, input int data,
                            input logic [CH-1:0] prst);
    int old_tick;
    int eff;
    int fb;
    old_tick = m_tick;
    m_pre  = (m_pre + 1) % PS;
    m_tick = (m_pre == PS - 1) ? 1 : 0;
    for (int c = 0; c < CH; c++) begin
      eff = (m_period[c] == 0) ? 1 : m_period[c];
      if (prst[c]) begin
        m_cnt[c] = 0;
        m_osc[c] = 0;
      end else if (old_tick != 0) begin
        if (m_cnt[c] + 1 >= eff) begin
          m_cnt[c] = 0;
          m_osc[c] = 1 - m_osc[c];
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
`ifdef SSG_NOISE_EN
    if (old_tick != 0) begin
      eff = (m_nper == 0) ? 1 : m_nper;
      if (m_ncnt + 1 >= eff) begin
        m_ncnt = 0;
        fb = (m_lfsr ^ (m_lfsr >> 3)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 16);
      end else begin
        m_ncnt = m_ncnt + 1;
      end
    end
    if (we != 0 && addr == CH) m_nper = data & 31;
`else
    fb = 0;
`endif
    if (we != 0 && addr < CH) m_period[addr] = data % (1 << PW);
  endtask

  // Driver: one cycle of stimulus, applied at the falling edge.
  task automatic drive(input int rst, input int we, input int addr, input int data,
                       input logic [CH-1:0] prst);
    @(negedge clk);
    rst_n         = (rst != 0);
    bus.WR_EN     = (we != 0);
    bus.WR_ADDR   = AW'(addr);
    bus.WR_DATA   = PW'(data);
    bus.PHASE_RST = prst;
    if (rst == 0) model_reset();
    else          model_edge(we, addr, data, prst);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, $urandom_range(0, 4095), '0);
  endtask

  task automatic wr(input int addr, input int data);
    drive(1, 1, addr, data, '0);
  endtask

  task automatic bound_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within bound, got timeout want reached", what);
  endtask

  // Monitor.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus.NOISE_OUT, bus.OSC_OUT, bus.TICK};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b want %b (noise,osc,tick)", cyc, got, exp);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [W-1:0] rst_val;
    int r;
    int n;
    bus.WR_EN     = 1'b0;
    bus.WR_ADDR   = '0;
    bus.WR_DATA   = '0;
    bus.PHASE_RST = '0;
    model_reset();

    // Asynchronous reset value, before any clock edge.
    #2;
    rst_val = model_out();
    checks++;
    if ({bus.NOISE_OUT, bus.OSC_OUT, bus.TICK} !== rst_val) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", {bus.NOISE_OUT, bus.OSC_OUT, bus.TICK}, rst_val);
    end

    // Reset held low with random inputs, then released.
    for (int k = 0; k < 6; k++)
      drive(0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4095),
            CH'($urandom_range(0, (1 << CH) - 1)));
    idle(20);

    // Channel 0 at period 2; channels 1 and 2 at period 0.
    wr(0, 2);
    idle(70);

    // Lower the period below the running count.
    wr(1, 100);
    idle(50 * PS);
    wr(1, 10);
    idle(200);

    // Write to channel 2 on an expiring tick under the old period.
    wr(2, 1);
    idle(2 * PS);
    n = 0;
    while (m_tick == 0 && n < 4 * PS) begin idle(1); n++; end
    if (m_tick == 0) bound_fail("align_tick_ch2");
    wr(2, 3);
    idle(60);

    // Phase reset on an expiring tick while channel 0 is high.
    n = 0;
    while (!(m_tick != 0 && m_osc[0] != 0 && m_cnt[0] + 1 >= 2) && n < 400) begin
      idle(1);
      n++;
    end
    if (n >= 400) bound_fail("align_prst_ch0");
    drive(1, 0, 0, 0, CH'(1));
    idle(40);

    // Noise period 0, then a write to the noise address with other values.
    wr(CH, 0);
    idle(40);
    wr(CH, 3);
    idle(60);

    // Reset in the middle of a count.
    drive(0, 0, 0, 0, '0);
    idle(30);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      r = $urandom_range(0, 199);
      if (r < 16) begin
        wr($urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095)
                                                            : $urandom_range(0, 12));
      end else if (r < 24) begin
        drive(1, 0, 0, $urandom_range(0, 4095), CH'($urandom_range(1, (1 << CH) - 1)));
      end else if (r < 26) begin
        drive(1, 1, $urandom_range(0, 3), $urandom_range(0, 12),
              CH'($urandom_range(1, (1 << CH) - 1)));
      end else if (r == 199) begin
        drive(0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4095), '0);
      end else begin
        idle(1);
      end
    end

    // Drain.
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin @(posedge clk); #2; n++; end
    if (exp_q.size() > 0) bound_fail("drain_exp_q");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
